// File: rtl/int_ctrl_pkg.sv
// ============================================================================
// Module      : int_ctrl_pkg
// Description : Shared types, default constants and vector helper for the
//               interrupt controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package int_ctrl_pkg;

    // Controller phases: waiting for work, offering a request, ISR running
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQUEST = 2'd1,
        SERVICE = 2'd2
    } int_state_t;

    localparam logic [31:0] c_default_vector_base   = 32'h0000_0004;
    localparam int          c_default_vector_stride = 4;

    // Vector address of a source, computed wide so callers can truncate
    function automatic logic [63:0] calc_vector(input logic [31:0] id,
                                                input logic [63:0] base,
                                                input logic [63:0] stride);
        return base + (64'(id) * stride);
    endfunction

endpackage

`default_nettype wire

// File: rtl/int_priority_arbiter.sv
// ============================================================================
// Module      : int_priority_arbiter
// Description : Combinational arbiter picking one eligible interrupt source.
//               Fixed priority (lowest index wins) by default; round-robin
//               starting after the last granted source when
//               INT_CTRL_ROUND_ROBIN_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module int_priority_arbiter #(
    parameter int NUM_SOURCES = 4,
    parameter int ID_WIDTH    = $clog2(NUM_SOURCES)
) (
    input  logic [NUM_SOURCES-1:0] i_eligible,
`ifdef INT_CTRL_ROUND_ROBIN_EN
    input  logic [ID_WIDTH-1:0]    i_last_granted,
`endif
    output logic                   o_valid,
    output logic [ID_WIDTH-1:0]    o_winner
);

`ifdef INT_CTRL_ROUND_ROBIN_EN
    // Scan from last_granted+1 with wraparound; walking the offsets downward
    // lets the nearest eligible source overwrite farther ones.
    always_comb begin
        int v_idx;
        o_valid  = 1'b0;
        o_winner = '0;
        v_idx    = 0;
        for (int k = NUM_SOURCES; k >= 1; k--) begin
            v_idx = (int'(i_last_granted) + k) % NUM_SOURCES;
            if (i_eligible[v_idx]) begin
                o_valid  = 1'b1;
                o_winner = ID_WIDTH'(v_idx);
            end
        end
    end
`else
    // Fixed priority: scan downward so the lowest eligible index is kept
    always_comb begin
        o_valid  = 1'b0;
        o_winner = '0;
        for (int i = NUM_SOURCES - 1; i >= 0; i--) begin
            if (i_eligible[i]) begin
                o_valid  = 1'b1;
                o_winner = ID_WIDTH'(i);
            end
        end
    end
`endif

endmodule

`default_nettype wire

// File: rtl/interrupt_controller.sv
// ============================================================================
// Module      : interrupt_controller
// Description : Latches rising edges of peripheral interrupt lines, arbitrates
//               among enabled pending sources and hands one at a time to the
//               CPU with a req/ack handshake, blocking until return-from-ISR.
//               Optional macro INT_CTRL_ROUND_ROBIN_EN selects round-robin
//               arbitration instead of fixed lowest-index priority.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module interrupt_controller
    import int_ctrl_pkg::*;
#(
    parameter int                      NUM_SOURCES   = 4,
    parameter int                      ID_WIDTH      = $clog2(NUM_SOURCES),
    parameter int                      VECTOR_WIDTH  = 32,
    parameter logic [VECTOR_WIDTH-1:0] VECTOR_BASE   = VECTOR_WIDTH'(c_default_vector_base),
    parameter int                      VECTOR_STRIDE = c_default_vector_stride
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_SOURCES-1:0]  irq_in,
    input  logic [NUM_SOURCES-1:0]  irq_enable,
    input  logic                    global_enable,
    output logic                    cpu_int_req,
    output logic [ID_WIDTH-1:0]     cpu_int_id,
    output logic [VECTOR_WIDTH-1:0] cpu_int_vector,
    input  logic                    cpu_int_ack,
    input  logic                    cpu_int_return,
    output logic [NUM_SOURCES-1:0]  pending,
    output logic                    in_service
);

    int_state_t              r_state;
    int_state_t              w_state_next;
    logic [NUM_SOURCES-1:0]  r_irq_prev;
    logic [NUM_SOURCES-1:0]  r_pending;
    logic [ID_WIDTH-1:0]     r_id;
    logic [NUM_SOURCES-1:0]  w_rise;
    logic [NUM_SOURCES-1:0]  w_eligible;
    logic [NUM_SOURCES-1:0]  w_clr_mask;
    logic                    w_ack_valid;
    logic                    w_load_id;
    logic                    w_arb_valid;
    logic [ID_WIDTH-1:0]     w_arb_winner;

    assign w_rise      = irq_in & ~r_irq_prev;
    assign w_eligible  = r_pending & irq_enable;
    assign w_ack_valid = (r_state == REQUEST) && cpu_int_ack;

`ifdef INT_CTRL_ROUND_ROBIN_EN
    logic [ID_WIDTH-1:0] r_last_granted;

    // Remember the most recently accepted source to rotate priority
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_last_granted <= ID_WIDTH'(NUM_SOURCES - 1);
        end else if (w_ack_valid) begin
            r_last_granted <= r_id;
        end
    end

    int_priority_arbiter #(
        .NUM_SOURCES (NUM_SOURCES),
        .ID_WIDTH    (ID_WIDTH)
    ) u_arbiter (
        .i_eligible     (w_eligible),
        .i_last_granted (r_last_granted),
        .o_valid        (w_arb_valid),
        .o_winner       (w_arb_winner)
    );
`else
    int_priority_arbiter #(
        .NUM_SOURCES (NUM_SOURCES),
        .ID_WIDTH    (ID_WIDTH)
    ) u_arbiter (
        .i_eligible (w_eligible),
        .o_valid    (w_arb_valid),
        .o_winner   (w_arb_winner)
    );
`endif

    // One-hot clear for the source the CPU just accepted
    always_comb begin
        w_clr_mask = '0;
        if (w_ack_valid) begin
            w_clr_mask[r_id] = 1'b1;
        end
    end

    // Edge history and pending flags; a new rise beats a same-cycle clear
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_irq_prev <= '0;
            r_pending  <= '0;
        end else begin
            r_irq_prev <= irq_in;
            r_pending  <= (r_pending & ~w_clr_mask) | w_rise;
        end
    end

    // State register plus the ID captured when a request is launched
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_id    <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_load_id) begin
                r_id <= w_arb_winner;
            end
        end
    end

    // Next-state logic; ack only counts in REQUEST, return only in SERVICE
    always_comb begin
        w_state_next = r_state;
        w_load_id    = 1'b0;
        case (r_state)
            IDLE: begin
                if (global_enable && w_arb_valid) begin
                    w_state_next = REQUEST;
                    w_load_id    = 1'b1;
                end
            end
            REQUEST: begin
                if (cpu_int_ack) begin
                    w_state_next = SERVICE;
                end
            end
            SERVICE: begin
                if (cpu_int_return) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // The vector is only driven while a source is offered or serviced, so
    // it reads as zero out of reset and between interrupts.
    assign cpu_int_req    = (r_state == REQUEST);
    assign in_service     = (r_state == SERVICE);
    assign cpu_int_id     = r_id;
    assign pending        = r_pending;
    assign cpu_int_vector = (cpu_int_req || in_service)
                          ? VECTOR_WIDTH'(calc_vector(32'(r_id), 64'(VECTOR_BASE),
                                                      64'(VECTOR_STRIDE)))
                          : '0;

endmodule

`default_nettype wire

// File: tb/tb_interrupt_controller.sv
// ============================================================================
// Module      : tb_interrupt_controller
// Description : Self-checking bench for interrupt_controller: a directed
//               table, hand-written corner sequences and randomized traffic,
//               all compared against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_interrupt_controller;

    localparam int NS = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  irq_in;
    logic [3:0]  irq_enable;
    logic        global_enable;
    logic        cpu_int_req;
    logic [1:0]  cpu_int_id;
    logic [31:0] cpu_int_vector;
    logic        cpu_int_ack;
    logic        cpu_int_return;
    logic [3:0]  pending;
    logic        in_service;

    int n_tests = 0;
    int n_fail  = 0;

    interrupt_controller dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .irq_in         (irq_in),
        .irq_enable     (irq_enable),
        .global_enable  (global_enable),
        .cpu_int_req    (cpu_int_req),
        .cpu_int_id     (cpu_int_id),
        .cpu_int_vector (cpu_int_vector),
        .cpu_int_ack    (cpu_int_ack),
        .cpu_int_return (cpu_int_return),
        .pending        (pending),
        .in_service     (in_service)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural reference model ----------------
    bit m_pend [NS];
    bit m_prev [NS];
    bit m_req;
    bit m_isr;
    int m_id;
    int m_last;

    function automatic int m_pick();
        int start;
        int s;
`ifdef INT_CTRL_ROUND_ROBIN_EN
        start = (m_last + 1) % NS;
`else
        start = 0;
`endif
        for (int k = 0; k < NS; k++) begin
            s = (start + k) % NS;
            if (m_pend[s] && irq_enable[s]) return s;
        end
        return -1;
    endfunction

    task automatic model_edge();
        int clr;
        int w;
        bit rise [NS];
        if (!rst_n) begin
            for (int i = 0; i < NS; i++) begin
                m_pend[i] = 1'b0;
                m_prev[i] = 1'b0;
            end
            m_req  = 1'b0;
            m_isr  = 1'b0;
            m_id   = 0;
            m_last = NS - 1;
        end else begin
            clr = -1;
            for (int i = 0; i < NS; i++) rise[i] = irq_in[i] && !m_prev[i];
            if (m_req && cpu_int_ack) begin
                clr    = m_id;
                m_req  = 1'b0;
                m_isr  = 1'b1;
                m_last = m_id;
            end else if (m_isr && cpu_int_return) begin
                m_isr = 1'b0;
            end else if (!m_req && !m_isr && global_enable) begin
                w = m_pick();
                if (w >= 0) begin
                    m_req = 1'b1;
                    m_id  = w;
                end
            end
            for (int i = 0; i < NS; i++) begin
                if (rise[i]) m_pend[i] = 1'b1;
                else if (i == clr) m_pend[i] = 1'b0;
                m_prev[i] = irq_in[i];
            end
        end
    endtask

    task automatic check_model(input string tag);
        logic [3:0]  ep;
        logic [31:0] ev;
        for (int i = 0; i < NS; i++) ep[i] = m_pend[i];
        ev = (m_req || m_isr) ? 32'(4 + 4 * m_id) : 32'h0;
        n_tests++;
        if ({cpu_int_req, cpu_int_id, cpu_int_vector, pending, in_service} !==
            {m_req, 2'(m_id), ev, ep, m_isr}) begin
            n_fail++;
            $display("FAIL model_%s t=%0t req/id/vec/pend/isvc got %b/%0d/%h/%b/%b expected %b/%0d/%h/%b/%b",
                     tag, $time, cpu_int_req, cpu_int_id, cpu_int_vector, pending, in_service,
                     m_req, m_id, ev, ep, m_isr);
        end
    endtask

    task automatic check_eq(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t got %0d expected %0d", tag, $time, got, exp);
        end
    endtask

    // Apply current inputs across one rising edge, then compare with model
    task automatic step(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        check_model(tag);
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic        rst_n;
        logic [3:0]  irq;
        logic        ack;
        logic        ret;
        logic        exp_req;
        logic [1:0]  exp_id;
        logic [31:0] exp_vec;
        logic [3:0]  exp_pend;
        logic        exp_isvc;
    } vec_t;

    vec_t tbl [18];

    initial begin
        int disp;
        bit prev_req;
        int exp_first;

        // rst, irq, ack, ret | req, id, vec, pend, in_service
        tbl[0]  = '{1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 32'h00, 4'b0000, 1'b0};
        tbl[1]  = '{1'b1, 4'b0100, 1'b0, 1'b0, 1'b0, 2'd0, 32'h00, 4'b0100, 1'b0};
        tbl[2]  = '{1'b1, 4'b0100, 1'b0, 1'b0, 1'b1, 2'd2, 32'h0C, 4'b0100, 1'b0};
        tbl[3]  = '{1'b1, 4'b0100, 1'b0, 1'b0, 1'b1, 2'd2, 32'h0C, 4'b0100, 1'b0};
        tbl[4]  = '{1'b1, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd2, 32'h0C, 4'b0000, 1'b1};
        tbl[5]  = '{1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd2, 32'h0C, 4'b0000, 1'b1};
        tbl[6]  = '{1'b1, 4'b0000, 1'b0, 1'b1, 1'b0, 2'd2, 32'h00, 4'b0000, 1'b0};
        tbl[7]  = '{1'b1, 4'b0000, 1'b0, 1'b1, 1'b0, 2'd2, 32'h00, 4'b0000, 1'b0};
        tbl[8]  = '{1'b1, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd2, 32'h00, 4'b0000, 1'b0};
        tbl[9]  = '{1'b1, 4'b1010, 1'b0, 1'b0, 1'b0, 2'd2, 32'h00, 4'b1010, 1'b0};
        tbl[10] = '{1'b1, 4'b1010, 1'b0, 1'b1, 1'b1, 2'd1, 32'h08, 4'b1010, 1'b0};
        tbl[11] = '{1'b1, 4'b1010, 1'b0, 1'b1, 1'b1, 2'd1, 32'h08, 4'b1010, 1'b0};
        tbl[12] = '{1'b1, 4'b1010, 1'b1, 1'b1, 1'b0, 2'd1, 32'h08, 4'b1000, 1'b1};
        tbl[13] = '{1'b1, 4'b1010, 1'b1, 1'b1, 1'b0, 2'd1, 32'h00, 4'b1000, 1'b0};
        tbl[14] = '{1'b1, 4'b1010, 1'b0, 1'b0, 1'b1, 2'd3, 32'h10, 4'b1000, 1'b0};
        tbl[15] = '{1'b1, 4'b1010, 1'b1, 1'b0, 1'b0, 2'd3, 32'h10, 4'b0000, 1'b1};
        tbl[16] = '{1'b1, 4'b0000, 1'b0, 1'b1, 1'b0, 2'd3, 32'h00, 4'b0000, 1'b0};
        tbl[17] = '{1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd3, 32'h00, 4'b0000, 1'b0};

        rst_n          = 1'b0;
        irq_in         = 4'b0000;
        irq_enable     = 4'b1111;
        global_enable  = 1'b1;
        cpu_int_ack    = 1'b0;
        cpu_int_return = 1'b0;

        for (int r = 0; r < 18; r++) begin
            rst_n          = tbl[r].rst_n;
            irq_in         = tbl[r].irq;
            cpu_int_ack    = tbl[r].ack;
            cpu_int_return = tbl[r].ret;
            step($sformatf("tbl%0d", r));
            n_tests++;
            if ({cpu_int_req, cpu_int_id, cpu_int_vector, pending, in_service} !==
                {tbl[r].exp_req, tbl[r].exp_id, tbl[r].exp_vec, tbl[r].exp_pend, tbl[r].exp_isvc}) begin
                n_fail++;
                $display("FAIL table_row%0d req/id/vec/pend/isvc got %b/%0d/%h/%b/%b expected %b/%0d/%h/%b/%b",
                         r, cpu_int_req, cpu_int_id, cpu_int_vector, pending, in_service,
                         tbl[r].exp_req, tbl[r].exp_id, tbl[r].exp_vec, tbl[r].exp_pend, tbl[r].exp_isvc);
            end
        end
        cpu_int_ack    = 1'b0;
        cpu_int_return = 1'b0;

        // Arbitration order after source 1 was last granted
        irq_in = 4'b0010; step("rr_a"); step("rr_b");
        check_eq("rr_first_single", cpu_int_id, 1);
        cpu_int_ack = 1'b1; step("rr_c"); cpu_int_ack = 1'b0;
        cpu_int_return = 1'b1; step("rr_d"); cpu_int_return = 1'b0;
        irq_in = 4'b0000; step("rr_e");
        irq_in = 4'b1010; step("rr_f"); step("rr_g");
`ifdef INT_CTRL_ROUND_ROBIN_EN
        exp_first = 3;
`else
        exp_first = 1;
`endif
        check_eq("rr_order_first", cpu_int_id, exp_first);
        check_eq("rr_order_req", cpu_int_req, 1);
        cpu_int_ack = 1'b1; step("rr_h"); cpu_int_ack = 1'b0;
        cpu_int_return = 1'b1; step("rr_i"); cpu_int_return = 1'b0;
        step("rr_j");
        check_eq("rr_order_second", cpu_int_id, 4 - exp_first);
        cpu_int_ack = 1'b1; step("rr_k"); cpu_int_ack = 1'b0;
        cpu_int_return = 1'b1; step("rr_l"); cpu_int_return = 1'b0;
        irq_in = 4'b0000; step("rr_m");

        // Masked source latches pending but is not dispatched until enabled
        irq_enable = 4'b1110;
        irq_in = 4'b0001; step("mask_a");
        irq_in = 4'b0000; step("mask_b"); step("mask_c"); step("mask_d");
        check_eq("mask_pending0", pending[0], 1);
        check_eq("mask_no_req", cpu_int_req, 0);
        irq_enable = 4'b1111; step("mask_e"); step("mask_f");
        check_eq("mask_req", cpu_int_req, 1);
        check_eq("mask_id", cpu_int_id, 0);
        cpu_int_ack = 1'b1; step("mask_g"); cpu_int_ack = 1'b0;
        cpu_int_return = 1'b1; step("mask_h"); cpu_int_return = 1'b0;

        // Level held high gives a single dispatch
        disp = 0;
        prev_req = 1'b0;
        irq_in = 4'b0010;
        for (int i = 0; i < 100; i++) begin
            cpu_int_ack    = cpu_int_req;
            cpu_int_return = in_service;
            step("level");
            if (cpu_int_req && !prev_req) disp++;
            prev_req = cpu_int_req;
        end
        cpu_int_ack = 1'b0; cpu_int_return = 1'b0;
        check_eq("level_one_dispatch", disp, 1);
        irq_in = 4'b0000; step("lvl_a");
        irq_in = 4'b0010; step("lvl_b"); step("lvl_c");
        cpu_int_ack = 1'b1; step("lvl_d"); cpu_int_ack = 1'b0;
        irq_in = 4'b0000; step("lvl_e");
        irq_in = 4'b0010; step("lvl_f");
        check_eq("svc_new_pending", pending[1], 1);
        check_eq("svc_still_busy", in_service, 1);
        cpu_int_return = 1'b1; step("lvl_g"); cpu_int_return = 1'b0;
        step("lvl_h");
        check_eq("redispatch_req", cpu_int_req, 1);
        check_eq("redispatch_id", cpu_int_id, 1);
        cpu_int_ack = 1'b1; step("lvl_i"); cpu_int_ack = 1'b0;
        cpu_int_return = 1'b1; step("lvl_j"); cpu_int_return = 1'b0;
        irq_in = 4'b0000; step("lvl_k");

        // global_enable cannot withdraw a request; blocks new ones in IDLE
        irq_in = 4'b0001; step("ge_a"); step("ge_b");
        global_enable = 1'b0; step("ge_c"); step("ge_d"); step("ge_e");
        check_eq("ge_hold_req", cpu_int_req, 1);
        check_eq("ge_hold_id", cpu_int_id, 0);
        cpu_int_ack = 1'b1; step("ge_f"); cpu_int_ack = 1'b0;
        cpu_int_return = 1'b1; step("ge_g"); cpu_int_return = 1'b0;
        irq_in = 4'b0100; step("ge_h");
        for (int i = 0; i < 4; i++) step("ge_idle");
        check_eq("ge_off_no_req", cpu_int_req, 0);
        check_eq("ge_off_pending", pending[2], 1);
        global_enable = 1'b1; step("ge_i");
        check_eq("ge_on_req", cpu_int_req, 1);
        cpu_int_ack = 1'b1; step("ge_j"); cpu_int_ack = 1'b0;
        cpu_int_return = 1'b1; step("ge_k"); cpu_int_return = 1'b0;
        irq_in = 4'b0000; step("ge_l");

        // Reset during SERVICE with other sources pending
        irq_in = 4'b0001; step("rst_a"); step("rst_b");
        cpu_int_ack = 1'b1; step("rst_c"); cpu_int_ack = 1'b0;
        irq_in = 4'b1011; step("rst_d");
        check_eq("rst_pre_pending", pending, 4'b1010);
        rst_n = 1'b0; irq_in = 4'b0000; step("rst_e");
        check_eq("rst_all_zero", {cpu_int_req, cpu_int_id, cpu_int_vector, pending, in_service}, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) step("rst_after");
        check_eq("rst_no_req", cpu_int_req, 0);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            for (int b = 0; b < NS; b++) begin
                if ($urandom_range(7) == 0) irq_in[b] = ~irq_in[b];
                irq_enable[b] = ($urandom_range(7) != 0);
            end
            global_enable  = ($urandom_range(9) != 0);
            cpu_int_ack    = ($urandom_range(3) == 0);
            cpu_int_return = ($urandom_range(3) == 0);
            rst_n          = ($urandom_range(199) != 0);
            step("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
